// File: rtl/featuremap_accumulator_pkg.sv
// featuremap_accumulator_pkg
//   Shared constants for the featuremap accumulator: activation encodings,
//   the leaky-ReLU shift amount and a ceil-log2 helper used for sizing.
package featuremap_accumulator_pkg;

  localparam int ACT_LINEAR = 0;
  localparam int ACT_RELU   = 1;
  localparam int ACT_LEAKY  = 2;

  // Leaky slope of 1/8 is an arithmetic right shift by 3.
  localparam int LEAKY_SHIFT = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/featuremap_adder_stage.sv
// featuremap_adder_stage
//   One registered level of the channel adder tree: adds adjacent pairs of
//   W-bit operands and registers the N_IN/2 results with a valid bit.
// Ports
//   clk_i    clock
//   rst_i    synchronous active-high reset (clears the valid bit only)
//   valid_i  data_i qualifier
//   data_i   N_IN packed operands, operand j at [j*W +: W]
//   valid_o  registered valid
//   data_o   N_IN/2 packed sums, sum j = operand 2j + operand 2j+1
module featuremap_adder_stage
  import featuremap_accumulator_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int W    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic [N_IN*W-1:0]       data_i,
  output logic                    valid_o,
  output logic [(N_IN/2)*W-1:0]   data_o
);

  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*W-1:0] sum_d;
  logic [N_OUT*W-1:0] sum_q;
  logic               valid_q;

  // Operands are already sign-extended to W, so plain two's-complement
  // addition cannot overflow.
  always_comb begin
    sum_d = '0;
    for (int j = 0; j < N_OUT; j++) begin
      sum_d[j*W +: W] = data_i[(2*j)*W +: W] + data_i[(2*j+1)*W +: W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= 1'b0;
    else       valid_q <= valid_i;
  end

  // Data only moves with a valid token; no reset needed on the datapath.
  always_ff @(posedge clk_i) begin
    if (valid_i) sum_q <= sum_d;
  end

  assign valid_o = valid_q;
  assign data_o  = sum_q;

endmodule

// File: rtl/featuremap_accumulator.sv
// featuremap_accumulator
//   Sums CH_NUM per-channel convolution results through a pipelined adder
//   tree, adds a programmable bias, applies the selected activation and
//   saturates to DATA_WIDTH. Tracks the pixel position within an
//   IMG_SIZE x IMG_SIZE frame and flags the last pixel.
//   Latency valid_in -> valid_out is log2(CH_NUM)+2 clock edges.
// Ports
//   Clk         clock, rising edge
//   Rst         synchronous active-high reset
//   data_in     CH_NUM channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_in    data_in qualifier, no backpressure
//   bias_in     bias value to load
//   bias_wr     single-cycle bias load strobe
//   data_out    activated, saturated pixel (holds while valid_out low)
//   valid_out   data_out qualifier
//   frame_last  high with the final pixel of each frame
//   bias_err    one-cycle pulse after a rejected bias write
module featuremap_accumulator
  import featuremap_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int CH_NUM     = 32,
  parameter int IMG_SIZE   = 104,
  parameter int ACT_MODE   = 2
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [CH_NUM*DATA_WIDTH-1:0] data_in,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      bias_in,
  input  logic                       bias_wr,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       valid_out,
  output logic                       frame_last,
  output logic                       bias_err
);

  localparam int LOG2     = clog2(CH_NUM);
  localparam int SUM_W    = DATA_WIDTH + LOG2 + 1;
  localparam int NPIX     = IMG_SIZE * IMG_SIZE;
  localparam int PIX_W    = (clog2(NPIX) < 1) ? 1 : clog2(NPIX);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  if ((1 << LOG2) != CH_NUM || CH_NUM < 2 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_param
    $error("featuremap_accumulator: illegal CH_NUM or FRAC_BITS");
  end

  // All tree levels packed back to back: level l starts at node offset
  // 2*CH_NUM - 2*(CH_NUM>>l); the final single sum is the last node.
  logic [(2*CH_NUM-1)*SUM_W-1:0] tree;
  logic [LOG2:0]                 vld;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_sext
    assign tree[k*SUM_W +: SUM_W] =
      {{(SUM_W-DATA_WIDTH){data_in[(k+1)*DATA_WIDTH-1]}},
       data_in[k*DATA_WIDTH +: DATA_WIDTH]};
  end

  assign vld[0] = valid_in;

  for (genvar l = 0; l < LOG2; l++) begin : g_lvl
    localparam int N_IN    = CH_NUM >> l;
    localparam int OFF_IN  = 2*CH_NUM - 2*(CH_NUM >> l);
    localparam int OFF_OUT = 2*CH_NUM - 2*(CH_NUM >> (l+1));
    featuremap_adder_stage #(
      .N_IN (N_IN),
      .W    (SUM_W)
    ) u_stage (
      .clk_i   (Clk),
      .rst_i   (Rst),
      .valid_i (vld[l]),
      .data_i  (tree[OFF_IN*SUM_W +: N_IN*SUM_W]),
      .valid_o (vld[l+1]),
      .data_o  (tree[OFF_OUT*SUM_W +: (N_IN/2)*SUM_W])
    );
  end

  logic signed [SUM_W-1:0]      tree_sum;
  logic signed [SUM_W-1:0]      bias_ext;
  logic [DATA_WIDTH-1:0]        bias_q;
  logic signed [SUM_W-1:0]      bias_sum_q;
  logic                         bias_vld_q;
  logic signed [SUM_W-1:0]      act_d;
  logic [DATA_WIDTH-1:0]        sat_d;
  logic [DATA_WIDTH-1:0]        data_out_q;
  logic                         valid_out_q;
  logic                         frame_last_q;
  logic                         bias_err_q;
  logic [PIX_W-1:0]             pix_q;
  logic [PIX_W-1:0]             pix_d;
  logic                         busy;

  assign tree_sum = tree[(2*CH_NUM-2)*SUM_W +: SUM_W];
  assign bias_ext = {{(SUM_W-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};

  // The bias may only change while nothing is entering or in flight, so
  // every pixel sees one consistent bias.
  assign busy = valid_in | (|vld[LOG2:1]) | bias_vld_q | valid_out_q;

  always_comb begin
    act_d = bias_sum_q;
    if (ACT_MODE == ACT_RELU && bias_sum_q[SUM_W-1]) begin
      act_d = '0;
    end else if (ACT_MODE == ACT_LEAKY && bias_sum_q[SUM_W-1]) begin
      act_d = bias_sum_q >>> LEAKY_SHIFT;
    end

    if (act_d > SAT_MAX)      sat_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (act_d < SAT_MIN) sat_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                      sat_d = act_d[DATA_WIDTH-1:0];
  end

  always_comb begin
    pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (vld[LOG2]) bias_sum_q <= tree_sum + bias_ext;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bias_q       <= '0;
      bias_err_q   <= 1'b0;
      bias_vld_q   <= 1'b0;
      valid_out_q  <= 1'b0;
      frame_last_q <= 1'b0;
      data_out_q   <= '0;
      pix_q        <= '0;
    end else begin
      if (bias_wr && !busy) bias_q <= bias_in;
      bias_err_q   <= bias_wr & busy;
      bias_vld_q   <= vld[LOG2];
      valid_out_q  <= bias_vld_q;
      frame_last_q <= bias_vld_q && (pix_q == PIX_LAST);
      if (bias_vld_q) begin
        data_out_q <= sat_d;
        pix_q      <= pix_d;
      end
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign frame_last = frame_last_q;
  assign bias_err   = bias_err_q;

endmodule

// File: doc/featuremap_accumulator.md
FEATUREMAP_ACCUMULATOR -- requirements
Module: featuremap_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed fixed-point width of each channel result, bias and output.
REQ-002 SHALL have parameter FRAC_BITS, default 8, number of fractional bits in all fixed-point values.
REQ-003 SHALL have parameter CH_NUM, default 32, number of input channels; a power of two, at least 2.
REQ-004 SHALL have parameter IMG_SIZE, default 104, output featuremap side length in pixels.
REQ-005 SHALL have parameter ACT_MODE, default 2, activation: 0 linear, 1 ReLU, 2 leaky (slope 1/8).
REQ-006 Clk  input  1  single clock; all logic on rising edge.
REQ-007 Rst  input  1  reset, synchronous and active-high.
REQ-008 data_in  input  CH_NUM*DATA_WIDTH  per-channel conv results; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 valid_in  input  1  data_in qualifier; no backpressure.
REQ-010 bias_in  input  DATA_WIDTH  bias value to load.
REQ-011 bias_wr  input  1  single-cycle bias load strobe.
REQ-012 data_out  output  DATA_WIDTH  activated, saturated featuremap pixel.
REQ-013 valid_out  output  1  data_out qualifier.
REQ-014 frame_last  output  1  high with the final pixel of each IMG_SIZE*IMG_SIZE frame.
REQ-015 bias_err  output  1  one-cycle pulse when a bias write is rejected.

Function
REQ-016 SHALL sum all CH_NUM channels in a pipelined binary adder tree with log2(CH_NUM) registered stages.
REQ-017 SHALL sign-extend the tree to DATA_WIDTH+log2(CH_NUM)+1 bits, so no intermediate overflow occurs.
REQ-018 SHALL add the sign-extended bias register in one registered stage after the tree.
REQ-019 SHALL apply the activation in the final registered stage, then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-020 ReLU SHALL output 0 for negative sums; leaky SHALL output the sum arithmetic-shifted right by 3 for negative sums (toward -infinity).
REQ-021 Latency from valid_in to valid_out SHALL be exactly log2(CH_NUM)+2 cycles, regardless of gaps in valid_in.
REQ-022 A valid shift register SHALL track data through the pipeline; stages holding invalid data SHALL NOT affect the outputs.
REQ-023 data_out SHALL hold its last value while valid_out is low.
REQ-024 A pixel counter SHALL increment on each valid_out and wrap from IMG_SIZE*IMG_SIZE-1 to 0.
REQ-025 frame_last SHALL be high in exactly the cycle valid_out carries counter value IMG_SIZE*IMG_SIZE-1.
REQ-026 bias_wr SHALL be accepted only when valid_in and every pipeline valid bit are 0; the bias register then updates on that edge.
REQ-027 A rejected bias_wr SHALL leave the bias unchanged and pulse bias_err in the next cycle.
REQ-028 When bias_wr and valid_in occur in the same cycle, the write SHALL be rejected and the pixel processed with the old bias.

Reset
REQ-029 On Rst, valid_out, frame_last, bias_err, data_out, the bias register, the pixel counter and all pipeline valid bits SHALL go to 0.
REQ-030 Rst asserted mid-frame SHALL discard all in-flight pixels; no valid_out SHALL appear until log2(CH_NUM)+2 cycles after the first post-reset valid_in.
REQ-031 Rst SHALL take priority over valid_in and bias_wr in the same cycle.

Structure
REQ-032 A shared package SHALL hold the ACT_MODE encodings, the leaky shift constant (3) and a ceil-log2 function.
REQ-033 One sub-module, featuremap_adder_stage, SHALL implement a single registered pairwise-add tree level and be generated log2(CH_NUM) times.

Verification
REQ-034 Use CH_NUM=4, DATA_WIDTH=16, FRAC_BITS=8 and IMG_SIZE=2 unless a scenario states otherwise.
REQ-035 Load bias 0x0080, then send all channels 0x0100 -> data_out 0x0480 with valid_out exactly 4 cycles later.
REQ-036 Send all channels 0x7FFF with bias 0 -> data_out 0x7FFF (saturated); send all channels 0x8000 with ACT_MODE=0 -> 0x8000.
REQ-037 ACT_MODE=2, channels {0xFE00 x4}, bias 0 (sum -8.0) -> data_out 0xFF00; ACT_MODE=1, same input -> 0x0000.
REQ-038 Send 8 pixels with random gaps -> frame_last high on the 4th and 8th valid_out only; bias_wr concurrent with valid_in -> bias_err pulse, bias unchanged.
REQ-039 Assert Rst while 2 pixels are in flight -> no valid_out from them; counter restarts so frame_last lands on the 4th post-reset output.
